// File: rtl/player_turn_ctrl_if.sv
// Control/indicator bundle for the two-player turn scheduler.
// PLAYER_TURN_PAUSE_EN adds the pauseReq input.
interface player_turn_ctrl_if;
  logic        startOfFrame;
  logic        gameStart;
  logic        gameOver;
  logic        turnDoneP0;
  logic        turnDoneP1;
`ifdef PLAYER_TURN_PAUSE_EN
  logic        pauseReq;
`endif
  logic        activePlayer;
  logic        indicatorEnable;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [7:0]  indicatorColor;
  logic [9:0]  framesLeft;
  logic        turnStartPulse;
  logic        timeoutPulse;

  modport master (
    output startOfFrame, gameStart, gameOver, turnDoneP0, turnDoneP1,
`ifdef PLAYER_TURN_PAUSE_EN
    output pauseReq,
`endif
    input  activePlayer, indicatorEnable, topLeftX, topLeftY, indicatorColor,
    input  framesLeft, turnStartPulse, timeoutPulse
  );

  modport slave (
    input  startOfFrame, gameStart, gameOver, turnDoneP0, turnDoneP1,
`ifdef PLAYER_TURN_PAUSE_EN
    input  pauseReq,
`endif
    output activePlayer, indicatorEnable, topLeftX, topLeftY, indicatorColor,
    output framesLeft, turnStartPulse, timeoutPulse
  );
endinterface

// File: rtl/player_turn_ctrl.sv
// Two-player turn scheduler: frame-counted turns, inter-turn gap, blinking indicator.
// Optional pause input enabled by defining PLAYER_TURN_PAUSE_EN.
module player_turn_ctrl #(
  parameter int         TURN_FRAMES  = 600,
  parameter int         WARN_FRAMES  = 120,
  parameter int         BLINK_FRAMES = 8,
  parameter int         GAP_FRAMES   = 30,
  parameter int         P0_X         = 600,
  parameter int         P0_Y         = 50,
  parameter int         P1_X         = 600,
  parameter int         P1_Y         = 100,
  parameter logic [7:0] P0_COLOR     = 8'h5b,
  parameter logic [7:0] P1_COLOR     = 8'hE0
) (
  input logic               clk,
  input logic               resetN,
  player_turn_ctrl_if.slave bus
);

  localparam logic [9:0]  TURN_L    = 10'(TURN_FRAMES);
  localparam logic [9:0]  WARN_L    = 10'(WARN_FRAMES);
  localparam logic [9:0]  BLINK_TOP = 10'(BLINK_FRAMES - 1);
  localparam logic [9:0]  GAP_L     = 10'(GAP_FRAMES);
  localparam logic [10:0] P0X       = 11'(P0_X);
  localparam logic [10:0] P0Y       = 11'(P0_Y);
  localparam logic [10:0] P1X       = 11'(P1_X);
  localparam logic [10:0] P1Y       = 11'(P1_Y);

  typedef enum logic [1:0] {IDLE, TURN, GAP, OVER} state_t;

  state_t     state, nxt_state;
  logic [9:0] fl_q, fl_d, gap_q, gap_d, bcnt_q, bcnt_d;
  logic       bph_q, bph_d, ap_q, ap_d;
  logic       en_d, tsp_d, top_d;
  logic       pause, sof, done_act;

`ifdef PLAYER_TURN_PAUSE_EN
  assign pause = bus.pauseReq;
`else
  assign pause = 1'b0;
`endif

  assign sof      = bus.startOfFrame;
  // Only the owner of the turn can end it; the other player's request is dropped.
  assign done_act = ap_q ? bus.turnDoneP1 : bus.turnDoneP0;

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else         state <= nxt_state;

  always_comb begin
    nxt_state = state;
    if (bus.gameOver) nxt_state = OVER;
    else begin
      case (state)
        IDLE, OVER: if (bus.gameStart) nxt_state = TURN;
        TURN:       if (!pause && (done_act || (sof && fl_q == 10'd1))) nxt_state = GAP;
        GAP:        if (!pause && sof && gap_q <= 10'd1) nxt_state = TURN;
        default:    nxt_state = IDLE;
      endcase
    end
  end

  always_comb begin
    fl_d   = fl_q;
    gap_d  = gap_q;
    bcnt_d = bcnt_q;
    bph_d  = bph_q;
    ap_d   = ap_q;
    top_d  = 1'b0;
    case (state)
      TURN: if (!bus.gameOver && !pause && !done_act && sof) begin
        fl_d = (fl_q != 10'd0) ? fl_q - 10'd1 : 10'd0;
        if (fl_q == 10'd1) top_d = 1'b1;
        if (fl_q <= WARN_L) begin
          if (bcnt_q == BLINK_TOP) begin
            bcnt_d = 10'd0;
            bph_d  = ~bph_q;
          end else begin
            bcnt_d = bcnt_q + 10'd1;
          end
        end
      end
      GAP: if (!bus.gameOver && !pause && sof && gap_q != 10'd0) gap_d = gap_q - 10'd1;
      default: ;
    endcase
    if (state == TURN && nxt_state == GAP) begin
      ap_d  = ~ap_q;
      gap_d = GAP_L;
    end
    // Turn entry from IDLE/OVER restarts with player 0; from GAP the owner already flipped.
    if (state != TURN && nxt_state == TURN) begin
      fl_d   = TURN_L;
      bcnt_d = 10'd0;
      bph_d  = 1'b1;
      if (state != GAP) ap_d = 1'b0;
    end
    tsp_d = (state != TURN) && (nxt_state == TURN);
    if (nxt_state != TURN)  en_d = 1'b0;
    else if (pause)         en_d = 1'b1;
    else if (fl_d > WARN_L) en_d = 1'b1;
    else                    en_d = bph_d;
  end

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      fl_q               <= 10'd0;
      gap_q              <= 10'd0;
      bcnt_q             <= 10'd0;
      bph_q              <= 1'b1;
      ap_q               <= 1'b0;
      bus.indicatorEnable <= 1'b0;
      bus.topLeftX       <= P0X;
      bus.topLeftY       <= P0Y;
      bus.indicatorColor <= P0_COLOR;
      bus.turnStartPulse <= 1'b0;
      bus.timeoutPulse   <= 1'b0;
    end else begin
      fl_q               <= fl_d;
      gap_q              <= gap_d;
      bcnt_q             <= bcnt_d;
      bph_q              <= bph_d;
      ap_q               <= ap_d;
      bus.indicatorEnable <= en_d;
      bus.topLeftX       <= ap_d ? P1X : P0X;
      bus.topLeftY       <= ap_d ? P1Y : P0Y;
      bus.indicatorColor <= ap_d ? P1_COLOR : P0_COLOR;
      bus.turnStartPulse <= tsp_d;
      bus.timeoutPulse   <= top_d;
    end

  assign bus.activePlayer = ap_q;
  assign bus.framesLeft   = fl_q;

endmodule

// File: tb/tb_player_turn_ctrl.sv
// Randomized + directed bench for player_turn_ctrl against a frame-level game model.
module tb_player_turn_ctrl;
  localparam int TF = 10, WF = 4, BF = 2, GF = 2;
  localparam int P0X = 600, P0Y = 50, P1X = 600, P1Y = 100;
  localparam int P0C = 'h5b, P1C = 'hE0;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  player_turn_ctrl_if bus();

  player_turn_ctrl #(.TURN_FRAMES(TF), .WARN_FRAMES(WF), .BLINK_FRAMES(BF), .GAP_FRAMES(GF))
    dut (.clk(clk), .resetN(resetN), .bus(bus));

  int checks = 0, errs = 0;

  // model: mode 0 idle, 1 playing, 2 between turns, 3 game over
  int m_mode, m_fl, m_gap;
  bit m_pl, m_tsp, m_top, pz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_pause(input bit p);
    pz = p;
`ifdef PLAYER_TURN_PAUSE_EN
    bus.pauseReq = p;
`endif
  endtask

  task automatic model_reset();
    m_mode = 0; m_pl = 0; m_fl = 0; m_gap = 0; m_tsp = 0; m_top = 0;
  endtask

  task automatic begin_turn();
    m_mode = 1; m_fl = TF; m_tsp = 1;
  endtask

  task automatic end_turn();
    m_mode = 2; m_pl = !m_pl; m_gap = GF;
  endtask

  task automatic model_clk();
    bit done;
    done = m_pl ? bus.turnDoneP1 : bus.turnDoneP0;
    m_tsp = 0; m_top = 0;
    if (bus.gameOver) m_mode = 3;
    else if (pz && (m_mode == 1 || m_mode == 2)) ;
    else case (m_mode)
      0, 3: if (bus.gameStart) begin m_pl = 0; begin_turn(); end
      1: if (done) end_turn();
         else if (bus.startOfFrame) begin
           if (m_fl == 1) begin m_fl = 0; m_top = 1; end_turn(); end
           else m_fl--;
         end
      2: if (bus.startOfFrame) begin
           m_gap--;
           if (m_gap == 0) begin_turn();
         end
      default: ;
    endcase
  endtask

  // Blink phase follows from how many frames have elapsed inside the warning window.
  function automatic bit exp_en();
    if (m_mode != 1) return 0;
    if (pz) return 1;
    if (m_fl > WF) return 1;
    return (((WF - m_fl) / BF) % 2) == 0;
  endfunction

  task automatic check_all();
    chk("activePlayer", bus.activePlayer, m_pl);
    chk("indicatorEnable", bus.indicatorEnable, exp_en());
    chk("topLeftX", bus.topLeftX, m_pl ? P1X : P0X);
    chk("topLeftY", bus.topLeftY, m_pl ? P1Y : P0Y);
    chk("indicatorColor", bus.indicatorColor, m_pl ? P1C : P0C);
    chk("framesLeft", bus.framesLeft, m_fl);
    chk("turnStartPulse", bus.turnStartPulse, m_tsp);
    chk("timeoutPulse", bus.timeoutPulse, m_top);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clk();
    #1;
    check_all();
  endtask

  task automatic frame();
    bus.startOfFrame = 1; cyc(); bus.startOfFrame = 0;
  endtask

  task automatic idle_in();
    bus.startOfFrame = 0; bus.gameStart = 0; bus.gameOver = 0;
    bus.turnDoneP0 = 0; bus.turnDoneP1 = 0; set_pause(0);
  endtask

  initial begin
    idle_in();
    resetN = 1; #1 resetN = 0; #2;
    model_reset();
    check_all();
    @(negedge clk) resetN = 1;

    // game start
    bus.gameStart = 1; cyc(); bus.gameStart = 0;
    chk("start_pulse", bus.turnStartPulse, 1);
    chk("start_frames", bus.framesLeft, TF);
    chk("start_color", bus.indicatorColor, P0C);
    cyc();

    // timeout of player 0, blinking in the warning window
    repeat (TF - 1) begin frame(); cyc(); end
    chk("pre_timeout_frames", bus.framesLeft, 1);
    chk("warn_blink_off", bus.indicatorEnable, 0);
    frame();
    chk("timeout_pulse", bus.timeoutPulse, 1);
    chk("timeout_frames", bus.framesLeft, 0);
    chk("gap_player", bus.activePlayer, 1);
    chk("gap_y", bus.topLeftY, P1Y);
    chk("gap_enable", bus.indicatorEnable, 0);
    cyc(); frame(); cyc(); frame();
    chk("gap_end_pulse", bus.turnStartPulse, 1);
    chk("gap_end_frames", bus.framesLeft, TF);
    cyc();

    // player 1 turn: the other player's done is ignored, own done switches
    bus.turnDoneP0 = 1; cyc(); bus.turnDoneP0 = 0;
    chk("ignored_done_en", bus.indicatorEnable, 1);
    bus.turnDoneP1 = 1; cyc(); bus.turnDoneP1 = 0;
    chk("done_player", bus.activePlayer, 0);
    chk("done_no_timeout", bus.timeoutPulse, 0);
    cyc(); frame(); cyc(); frame(); cyc();

    // done coincident with the final frame: single switch, no timeout
    repeat (TF - 1) begin frame(); cyc(); end
    bus.turnDoneP1 = 1; cyc(); bus.turnDoneP1 = 0;
    bus.turnDoneP0 = 1; bus.startOfFrame = 1; cyc();
    bus.turnDoneP0 = 0; bus.startOfFrame = 0;
    chk("simul_player", bus.activePlayer, 1);
    chk("simul_timeout", bus.timeoutPulse, 0);
    cyc(); frame(); cyc(); frame(); cyc();
    frame(); cyc();

    // game over overrides start, freezes framesLeft
    bus.gameOver = 1; bus.gameStart = 1; cyc(); bus.gameStart = 0;
    chk("over_enable", bus.indicatorEnable, 0);
    chk("over_frames", bus.framesLeft, TF - 1);
    repeat (3) begin frame(); cyc(); end
    chk("over_frozen", bus.framesLeft, TF - 1);
    bus.gameOver = 0; cyc();
    bus.gameStart = 1; cyc(); bus.gameStart = 0;
    chk("restart_player", bus.activePlayer, 0);
    chk("restart_frames", bus.framesLeft, TF);

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      bus.startOfFrame = ($urandom_range(0, 3) == 0);
      bus.gameStart    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 149) == 0) bus.gameOver = !bus.gameOver;
      bus.turnDoneP0   = ($urandom_range(0, 39) == 0);
      bus.turnDoneP1   = ($urandom_range(0, 39) == 0);
`ifdef PLAYER_TURN_PAUSE_EN
      set_pause($urandom_range(0, 9) == 0);
`endif
      cyc();
    end
    idle_in(); cyc();

    // async reset while in the gap
    bus.gameStart = 1; cyc(); bus.gameStart = 0;
    bus.turnDoneP0 = 1; bus.turnDoneP1 = 1; cyc();
    bus.turnDoneP0 = 0; bus.turnDoneP1 = 0;
    chk("pre_reset_gap", bus.indicatorEnable, 0);
    #2 resetN = 0; #1;
    model_reset();
    check_all();
    @(posedge clk); #1 resetN = 1;
    cyc();

`ifdef PLAYER_TURN_PAUSE_EN
    bus.gameStart = 1; cyc(); bus.gameStart = 0;
    frame(); cyc(); frame(); cyc();
    set_pause(1);
    repeat (5) begin frame(); cyc(); end
    chk("pause_frames", bus.framesLeft, TF - 2);
    chk("pause_enable", bus.indicatorEnable, 1);
    set_pause(0); cyc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule

// File: doc/player_turn_ctrl.md
Name: player_turn_ctrl

Overview:
- Turn scheduler for the two-player game.
- Decides which player owns the current turn and counts the turn time in video frames.
- Drives the position, colour and enable of the shared player indicator square, which is instantiated with fixed per-player placement. The pixel-level square object consumes topLeftX/topLeftY/indicatorColor/indicatorEnable from this block.
- Switches turns on a player's done request or on timeout, and blinks the indicator as the turn nears its end.

Parameters:
TURN_FRAMES, 600, frames per turn (10 s at 60 Hz); max 1023
WARN_FRAMES, 120, remaining-frame threshold at which blinking starts; must be < TURN_FRAMES
BLINK_FRAMES, 8, frames per blink half-period; >= 1
GAP_FRAMES, 30, frames of indicator-off gap between turns; >= 1
P0_X, 600, indicator top-left X for player 0
P0_Y, 50, indicator top-left Y for player 0
P1_X, 600, indicator top-left X for player 1
P1_Y, 100, indicator top-left Y for player 1
P0_COLOR, 8'h5b, indicator colour for player 0
P1_COLOR, 8'hE0, indicator colour for player 1

Ports:
clk  in  1  system/VGA clock
resetN  in  1  asynchronous reset, active-low
startOfFrame  in  1  one-cycle pulse per video frame
gameStart  in  1  level/pulse; starts or restarts the game
gameOver  in  1  level; ends the game
turnDoneP0  in  1  player 0 ends its turn (pulse)
turnDoneP1  in  1  player 1 ends its turn (pulse)
activePlayer  out  1  current/next turn owner (0/1)
indicatorEnable  out  1  indicator square drawn when 1
topLeftX  out  11  indicator X position
topLeftY  out  11  indicator Y position
indicatorColor  out  8  indicator colour
framesLeft  out  10  remaining frames in current turn
turnStartPulse  out  1  one cycle at entry to a TURN state
timeoutPulse  out  1  one cycle when a turn ends by timeout

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE, activePlayer 0, indicatorEnable 0
  - topLeftX P0_X, topLeftY P0_Y, indicatorColor P0_COLOR
  - framesLeft 0, both pulses 0, blinkCnt 0, blinkPhase 1
- States: IDLE, TURN, GAP, OVER.
- IDLE:
  - indicator off.
  - gameStart -> TURN next cycle with activePlayer=0, framesLeft=TURN_FRAMES, blinkPhase=1, blinkCnt=0, turnStartPulse=1.
- TURN:
  - Counting:
    - indicatorEnable = 1 while framesLeft > WARN_FRAMES, else blinkPhase.
    - On each startOfFrame, framesLeft decrements.
    - While framesLeft <= WARN_FRAMES, blinkCnt increments per frame; on reaching BLINK_FRAMES it clears and blinkPhase toggles.
  - End of turn (checked in priority order):
    - Done: turnDone of the active player -> GAP.
    - Ignored done: turnDone of the inactive player is ignored.
    - Timeout: startOfFrame with framesLeft==1 -> framesLeft 0, timeoutPulse=1, -> GAP.
    - Simultaneous done and timeout in the same cycle: exactly one switch, timeoutPulse=0 (done wins).
- GAP:
  - indicatorEnable=0.
  - activePlayer toggles on entry; position and colour update to the new player in the same cycle.
  - Gap counter loads GAP_FRAMES and decrements per startOfFrame.
  - At 0 -> TURN, with the same init as from IDLE and turnStartPulse=1.
- OVER:
  - indicator off, framesLeft frozen.
  - gameStart (with gameOver low) -> TURN for player 0.
- Global priority and latency:
  - gameOver high in any state -> OVER next cycle; this overrides done, timeout and gameStart.
  - Outputs reflect a state change one clk after the causing input.
- Position and colour mux: activePlayer selects P0_*/P1_*.
- Reset:
  - Reset assertion mid-turn forces the reset values immediately (asynchronous).
  - After deassertion the block waits in IDLE.
- Width rules:
  - framesLeft never underflows; it saturates at 0.
  - Positions are zero-extended to 11 bits.

Optional Feature:
- Macro: PLAYER_TURN_PAUSE_EN.
- Defined:
  - Adds input port pauseReq (1 bit).
  - While pauseReq=1 in TURN or GAP: all frame counters, blinkCnt and blinkPhase hold, turnDone inputs are ignored, and indicatorEnable is held 1 (steady) in TURN.
  - gameOver still takes effect.
- Undefined: no port; counters always run.

Test Plan:
- Params TURN=10, WARN=4, BLINK=2, GAP=2. Reset, then gameStart -> turnStartPulse 1 cycle, activePlayer 0, framesLeft 10, topLeft (600,50), colour 5b, enable 1.
- Timeout: 10 frames without done -> framesLeft 0, timeoutPulse 1 cycle. Indicator blinks from framesLeft 4, toggling every 2 frames. Then GAP enable 0, activePlayer 1, topLeft (600,100), colour E0. After 2 frames -> TURN, framesLeft 10.
- Done handling: turnDoneP1 during player 0's turn -> no change. turnDoneP0 -> GAP next cycle, timeoutPulse 0.
- Simultaneous: turnDoneP0 coincident with the final startOfFrame -> single switch to player 1, timeoutPulse 0.
- Game over: gameOver asserted with gameStart, mid-TURN -> OVER, enable 0, framesLeft frozen. Release gameOver, pulse gameStart -> TURN, player 0, framesLeft 10.
- Async reset mid-GAP -> all outputs at reset values before the next clk edge. With PLAYER_TURN_PAUSE_EN: pauseReq for 5 frames mid-turn -> framesLeft unchanged, enable 1.
